// File: rtl/cpu_pkg.sv
// Shared types and constants for the multi-cycle CPU controller.
package cpu_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned REG_AW  = 3;

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_GETA, S_GETB, S_EXEC, S_WREG, S_WIMM, S_HALT
  } state_e;

  typedef struct packed {
    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [1:0] sh;
    logic [2:0] rm;
  } ir_t;

  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  localparam logic [1:0] WB_C    = 2'b00;
  localparam logic [1:0] WB_IMM8 = 2'b10;

endpackage

// File: rtl/cpu_controller_instr_decoder.sv
// Combinational IR decode: register fields, sign-extended immediates and
// one-hot instruction class.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [15:0] ir_i,
  output logic [1:0]  op_o,
  output logic [2:0]  rn_o,
  output logic [2:0]  rd_o,
  output logic [1:0]  sh_o,
  output logic [2:0]  rm_o,
  output logic [15:0] sximm5_o,
  output logic [15:0] sximm8_o,
  output logic        is_mov_imm_o,
  output logic        is_mov_reg_o,
  output logic        is_alu_o,
  output logic        is_cmp_o,
  output logic        is_mvn_o,
  output logic        is_halt_o
);

  ir_t f;
  assign f = ir_i;

  assign op_o = f.op;
  assign rn_o = f.rn;
  assign rd_o = f.rd;
  assign sh_o = f.sh;
  assign rm_o = f.rm;

  assign sximm8_o = {{8{ir_i[7]}}, ir_i[7:0]};
  assign sximm5_o = {{11{ir_i[4]}}, ir_i[4:0]};

  // is_alu covers the two-operand results written back (ADD, AND)
  always_comb begin
    is_mov_imm_o = 1'b0;
    is_mov_reg_o = 1'b0;
    is_alu_o     = 1'b0;
    is_cmp_o     = 1'b0;
    is_mvn_o     = 1'b0;
    is_halt_o    = 1'b0;
    case (f.opcode)
      OPC_MOV: begin
        is_mov_imm_o = (f.op == OP_MOV_IMM);
        is_mov_reg_o = (f.op == OP_MOV_REG);
      end
      OPC_ALU: begin
        is_cmp_o = (f.op == ALU_CMP);
        is_mvn_o = (f.op == ALU_MVN);
        is_alu_o = (f.op == ALU_ADD) || (f.op == ALU_AND);
      end
      OPC_HALT: is_halt_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_controller.sv
// Multi-cycle control FSM for the CPU datapath.
// Optional retired-instruction counter enabled by CPU_INSTR_COUNT_EN.
module cpu_controller
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] instr,
  input  logic        start,
  output logic        waiting,
  output logic        halted,
  output logic        illegal,
  output logic [1:0]  wb_sel,
  output logic [2:0]  w_addr,
  output logic        w_en,
  output logic [2:0]  r_addr,
  output logic        en_A,
  output logic        en_B,
  output logic [1:0]  shift_op,
  output logic        sel_A,
  output logic        sel_B,
  output logic [1:0]  ALU_op,
  output logic        en_C,
  output logic        en_status,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5,
  output logic [15:0] instr_count
);

  state_e             state_q;
  logic [INSTR_W-1:0] ir_q;
  logic               illegal_q;

  logic [1:0]        op;
  logic [REG_AW-1:0] rn, rd, rm;
  logic [1:0]        sh;
  logic              is_mov_imm, is_mov_reg, is_alu, is_cmp, is_mvn, is_halt;

  instr_decoder u_dec (
    .ir_i         (ir_q),
    .op_o         (op),
    .rn_o         (rn),
    .rd_o         (rd),
    .sh_o         (sh),
    .rm_o         (rm),
    .sximm5_o     (sximm5),
    .sximm8_o     (sximm8),
    .is_mov_imm_o (is_mov_imm),
    .is_mov_reg_o (is_mov_reg),
    .is_alu_o     (is_alu),
    .is_cmp_o     (is_cmp),
    .is_mvn_o     (is_mvn),
    .is_halt_o    (is_halt)
  );

  // IR and illegal only change in S_WAIT/S_DECODE, so IR is stable mid-instruction
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_WAIT;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        S_WAIT: begin
          if (load) begin
            ir_q      <= instr;
            illegal_q <= 1'b0;
          end
          if (start) state_q <= S_DECODE;
        end
        S_DECODE: begin
          if (is_mov_imm)                state_q <= S_WIMM;
          else if (is_mov_reg || is_mvn) state_q <= S_GETB;
          else if (is_alu || is_cmp)     state_q <= S_GETA;
          else if (is_halt)              state_q <= S_HALT;
          else begin
            illegal_q <= 1'b1;
            state_q   <= S_WAIT;
          end
        end
        S_GETA:         state_q <= S_GETB;
        S_GETB:         state_q <= S_EXEC;
        S_EXEC:         state_q <= is_cmp ? S_WAIT : S_WREG;
        S_WREG, S_WIMM: state_q <= S_WAIT;
        S_HALT:         state_q <= S_HALT;
        default:        state_q <= S_WAIT;
      endcase
    end
  end

  assign illegal = illegal_q;

  // Moore control strobes decoded from state and IR
  always_comb begin
    waiting   = 1'b0;
    halted    = 1'b0;
    wb_sel    = WB_C;
    w_addr    = rd;
    w_en      = 1'b0;
    r_addr    = rm;
    en_A      = 1'b0;
    en_B      = 1'b0;
    shift_op  = sh;
    sel_A     = 1'b0;
    sel_B     = 1'b0;
    ALU_op    = ALU_ADD;
    en_C      = 1'b0;
    en_status = 1'b0;
    case (state_q)
      S_WAIT: waiting = 1'b1;
      S_GETA: begin
        r_addr = rn;
        en_A   = 1'b1;
      end
      S_GETB: en_B = 1'b1;
      S_EXEC: begin
        sel_A = is_alu || is_cmp;
        ALU_op = is_mov_reg ? ALU_ADD : op;
        if (is_cmp) en_status = 1'b1;
        else        en_C      = 1'b1;
      end
      S_WREG: w_en = 1'b1;
      S_WIMM: begin
        w_addr = rn;
        wb_sel = WB_IMM8;
        w_en   = 1'b1;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

`ifdef CPU_INSTR_COUNT_EN
  logic [15:0] count_q;
  logic        retire_c;

  assign retire_c = (state_q == S_WREG) || (state_q == S_WIMM) ||
                    ((state_q == S_EXEC) && is_cmp);

  always_ff @(posedge clk) begin
    if (reset)         count_q <= '0;
    else if (retire_c) count_q <= count_q + 16'(1);
  end

  assign instr_count = count_q;
`else
  assign instr_count = '0;
`endif

endmodule
